// File: rtl/cop_ise_pipe.sv
// Ascon sigma ISE coprocessor: decode, capture, multi-cycle compute, handshake writeback.
// Ports: cop_clk/cop_rst clock and sync reset; cop_valid/cop_insn/cop_rs1/cop_rs2 issue side;
// cop_ready/cop_wait status; cop_rdywr/cop_wr/cop_rd writeback handshake and data.
module cop_ise_pipe #(
    parameter logic [1:0] ISE_V = 2'b11,
    parameter int         XLEN  = 32,
    parameter int         LAT   = 1
) (
    input  logic            cop_clk,
    input  logic            cop_rst,
    input  logic            cop_valid,
    input  logic            cop_rdywr,
    input  logic [31:0]     cop_insn,
    input  logic [XLEN-1:0] cop_rs1,
    input  logic [XLEN-1:0] cop_rs2,
    output logic            cop_ready,
    output logic            cop_wait,
    output logic            cop_wr,
    output logic [XLEN-1:0] cop_rd
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter preload; LAT=1 skips CALC so the value is irrelevant there.
    localparam logic [1:0] CNT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    logic [1:0]      state;
    logic [1:0]      cnt;
    logic [63:0]     x_q;
    logic            op_q;
    logic [2:0]      imm_q;

    logic [63:0]     x_in;
    logic            op_ok;
    logic            sel;
    logic [5:0]      r0;
    logic [5:0]      r1;
    logic [63:0]     y;
    logic [XLEN-1:0] rd_val;

    function automatic logic [63:0] ror64(input logic [63:0] v, input logic [5:0] n);
        ror64 = (v >> n) | (v << (7'd64 - {1'b0, n}));
    endfunction

    if (XLEN == 32) begin : g_x32
        assign x_in   = {cop_rs2, cop_rs1};
        assign op_ok  = ~cop_insn[31];
        assign rd_val = op_q ? y[63:32] : y[31:0];
        wire unused_bits = ^cop_insn[24:7];
    end else begin : g_x64
        assign x_in   = cop_rs1;
        assign op_ok  = (cop_insn[31:30] == 2'b00);
        assign rd_val = y;
        wire unused_bits = ^{cop_insn[24:7], cop_rs2, op_q};
    end

    assign sel = ISE_V[1]
               && (cop_insn[6:0] == 7'b0101011)
               && (cop_insn[29:25] <= 5'd4)
               && op_ok;

    always_comb begin
        r0 = 6'd0;
        r1 = 6'd0;
        case (imm_q)
            3'd0: begin r0 = 6'd19; r1 = 6'd28; end
            3'd1: begin r0 = 6'd61; r1 = 6'd39; end
            3'd2: begin r0 = 6'd1;  r1 = 6'd6;  end
            3'd3: begin r0 = 6'd10; r1 = 6'd17; end
            3'd4: begin r0 = 6'd7;  r1 = 6'd41; end
            default: begin r0 = 6'd0; r1 = 6'd0; end
        endcase
    end

    // Result is purely a function of the captured operands.
    assign y = x_q ^ ror64(x_q, r0) ^ ror64(x_q, r1);

    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
            x_q   <= 64'd0;
            op_q  <= 1'b0;
            imm_q <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cop_valid && sel) begin
                        x_q   <= x_in;
                        op_q  <= cop_insn[30];
                        imm_q <= cop_insn[27:25];
                        cnt   <= CNT_INIT;
                        state <= (LAT == 1) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt == 2'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    if (cop_rdywr) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cop_ready = (state == S_IDLE) || ((state == S_DONE) && cop_rdywr);
    assign cop_wait  = (state == S_CALC);
    assign cop_wr    = (state == S_DONE);
    assign cop_rd    = (state == S_DONE) ? rd_val : '0;

endmodule

// File: doc/cop_ise_pipe.md
COP_ISE_PIPE -- requirements
Module: cop_ise_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ISE_V, 2'b11, feature vector; bit 1 = Ascon sigma ops present.
- XLEN, 32, datapath width; legal values 32, 64.
- LAT, 1, issue-to-result latency in cycles; legal values 1..4.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- cop_clk, in, 1, clock.
- cop_rst, in, 1, reset.
- cop_valid, in, 1, instruction offered.
- cop_rdywr, in, 1, core able to accept writeback.
- cop_insn, in, 32, instruction word.
- cop_rs1, in, XLEN, source operand 1.
- cop_rs2, in, XLEN, source operand 2.
- cop_ready, out, 1, block able to take or retire an instruction.
- cop_wait, out, 1, computation in progress.
- cop_wr, out, 1, writeback valid.
- cop_rd, out, XLEN, writeback data.
REQ-003 The block SHALL use one clock, cop_clk; reset is synchronous and active-high on cop_rst.

Function
REQ-004 Decode SHALL assert sel when cop_insn[6:0]=7'b0101011, imm=cop_insn[29:25] <= 4, ISE_V[1]=1, and the op is legal for XLEN: funct[6:5]=00 (sigma_lo) or 01 (sigma_hi) when XLEN=32; 00 only (sigma, full word) when XLEN=64.
REQ-005 The 64-bit operand x SHALL be {rs2,rs1} when XLEN=32 and rs1 when XLEN=64.
REQ-006 The result SHALL be y = x ^ ror64(x,r0) ^ ror64(x,r1), where (r0,r1) per imm 0..4 = (19,28), (61,39), (1,6), (10,17), (7,41).
REQ-007 The written value SHALL be y[31:0] for sigma_lo, y[63:32] for sigma_hi, and y for XLEN=64.
REQ-008 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-009 In IDLE with cop_valid=1 and sel=1, the block SHALL capture rs1, rs2, op, and imm into registers, then go to DONE if LAT=1, else to CALC with a 2-bit counter loaded with LAT-2.
REQ-010 In IDLE with cop_valid=0 or sel=0, the block SHALL stay in IDLE and capture nothing; a non-matching instruction SHALL produce cop_wr=0 and cop_ready=1.
REQ-011 CALC SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reads 0, giving LAT-1 cycles in CALC. The datapath MAY be retimed across CALC cycles, but the result SHALL depend only on the captured operands.
REQ-012 In DONE the block SHALL drive cop_wr=1 with cop_rd equal to the result.
- If cop_rdywr=1: go to IDLE; cop_ready=1 in that cycle.
- Else: stay in DONE with cop_rd held stable; cop_ready=0.
REQ-013 cop_wr SHALL first be asserted exactly LAT cycles after the accepting cycle.
REQ-014 Output levels per state SHALL be:
- IDLE: cop_ready=1, cop_wait=0, cop_wr=0, cop_rd=0.
- CALC: cop_ready=0, cop_wait=1, cop_wr=0, cop_rd=0.
REQ-015 cop_valid and the operand inputs SHALL be ignored outside IDLE. Input changes after acceptance SHALL NOT alter the result.
REQ-016 Back-to-back issue SHALL be supported: a new instruction is accepted no earlier than the cycle after DONE retires, so the minimum issue interval is LAT+1 cycles.
REQ-017 With ISE_V[1]=0, sel SHALL be constant 0, the FSM SHALL never leave IDLE, and cop_rd SHALL be 0.

Reset
REQ-018 With cop_rst=1 at a clock edge, the next state SHALL be IDLE, the counter 0, and all capture registers 0. Outputs SHALL then read cop_ready=1, cop_wait=0, cop_wr=0, cop_rd=0.
REQ-019 Reset in CALC or DONE SHALL abandon the pending result with no cop_wr pulse afterwards. Reset SHALL take priority over a simultaneous cop_valid.

Verification
REQ-020 XLEN=32, LAT=1: sigma_hi, imm=0, rs1=32'h00000001, rs2=0, cop_rdywr=1. Required: cop_wr=1 one cycle later with cop_rd=32'h00002010. The same test with sigma_lo gives 32'h00000001.
REQ-021 XLEN=32, LAT=3: sigma_hi, imm=2, rs1=1, rs2=0. Required: cop_wait=1 for 2 cycles, then cop_wr=1 with cop_rd=32'h84000000 at acceptance+3.
REQ-022 Stall: hold cop_rdywr=0 for 5 cycles in DONE. Required: cop_wr=1, cop_ready=0, cop_rd unchanged throughout; on cop_rdywr=1, cop_ready=1 and IDLE next cycle. Operand changes during the stall SHALL have no effect.
REQ-023 Decode: opcode CUSTOM_0, imm=5, and (for XLEN=64) funct[6:5]=01, each with cop_valid=1. Required: cop_wr never asserted, cop_ready stays 1.
REQ-024 XLEN=64, LAT=2: imm=0, rs1=64'h1. Required: cop_rd=64'h0000201000000001 at acceptance+2.
REQ-025 Reset: assert cop_rst in CALC and, separately, in DONE. Required: outputs at reset values next cycle and no stray cop_wr; a fresh issue afterwards completes correctly.
